// File: rtl/multi_cycle_ctrl_if.sv
`default_nettype none
//============================================================================
// Module      : multi_cycle_ctrl_if
// Description : Bundle between the multi-cycle MIPS control unit and the
//               shared datapath it steers.
//               Inputs to the controller:
//                 opCode[5:0]  - IR[31:26]
//                 memReady     - memory finishes the current access this cycle
//               Outputs from the controller:
//                 pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
//                 memToReg, regDest, regWrite, aluSrcA   - 1-bit controls
//                 aluSrcB[1:0]  - 00 B, 01 +4, 10 imm, 11 imm<<2
//                 aluOp[1:0]    - 00 add, 01 sub, 10 funct-decoded
//                 pcSource[1:0] - 00 ALU, 01 ALUOut, 10 jump target
//                 instrDone     - pulse on the last cycle of an instruction
//                 illegalOp     - pulse in DECODE on an illegal opcode,
//                                 held high while halted
//               Modports: master = control unit, slave = datapath side.
// Revision    : 1.0 - initial release
//============================================================================
interface multi_cycle_ctrl_if;
    logic [5:0] opCode;
    logic       memReady;

    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDest;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
    logic       illegalOp;

    modport master (
        input  opCode, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDest, regWrite, aluSrcA, aluSrcB, aluOp,
               pcSource, instrDone, illegalOp
    );

    modport slave (
        output opCode, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDest, regWrite, aluSrcA, aluSrcB, aluOp,
               pcSource, instrDone, illegalOp
    );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
//============================================================================
// Module      : multi_cycle_ctrl
// Description : Moore control FSM for a multi-cycle MIPS datapath. Sequences
//               fetch / decode / execute / memory / write-back with a
//               variable-latency memory handshake, optional addi support and
//               a selectable illegal-opcode policy (skip or halt).
//               Ports:
//                 clk    - rising-edge clock
//                 reset  - synchronous, active-high; forces FETCH
//                 bus    - multi_cycle_ctrl_if.master (opCode, memReady in;
//                          datapath controls, instrDone, illegalOp out)
//               Parameters:
//                 ADDI_EN         - 1 accepts addi (001000), 0 treats it as
//                                   illegal
//                 HALT_ON_ILLEGAL - 1 parks in HALT until reset, 0 skips the
//                                   offending instruction
// Revision    : 1.0 - initial release
//============================================================================
module multi_cycle_ctrl #(
    parameter bit ADDI_EN         = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    multi_cycle_ctrl_if.master bus
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    // The address-calculation step is split into a load flavour and a store
    // flavour so the lw/sw choice is made once, in DECODE. The state register
    // then carries it and opCode is never consulted outside DECODE.
    typedef enum logic [3:0] {
        S_FETCH       = 4'd0,
        S_DECODE      = 4'd1,
        S_MEM_ADDR_LW = 4'd2,
        S_MEM_ADDR_SW = 4'd3,
        S_MEM_READ    = 4'd4,
        S_MEM_WB      = 4'd5,
        S_MEM_WRITE   = 4'd6,
        S_EXECUTE     = 4'd7,
        S_R_WB        = 4'd8,
        S_BRANCH      = 4'd9,
        S_JUMP        = 4'd10,
        S_ADDI_EXEC   = 4'd11,
        S_ADDI_WB     = 4'd12,
        S_HALT        = 4'd13
    } state_t;

    state_t r_state;
    state_t w_nextState;
    state_t w_outState;

    logic w_opLegal;

    logic       w_pcWrite;
    logic       w_pcWriteCond;
    logic       w_iorD;
    logic       w_memRead;
    logic       w_memWrite;
    logic       w_irWrite;
    logic       w_memToReg;
    logic       w_regDest;
    logic       w_regWrite;
    logic       w_aluSrcA;
    logic [1:0] w_aluSrcB;
    logic [1:0] w_aluOp;
    logic [1:0] w_pcSource;
    logic       w_instrDone;
    logic       w_illegalOp;

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    //------------------------------------------------------------------------
    // Opcode legality (only meaningful while in DECODE)
    //------------------------------------------------------------------------
    always_comb begin
        w_opLegal = 1'b0;
        case (bus.opCode)
            c_OP_RTYPE,
            c_OP_LW,
            c_OP_SW,
            c_OP_BEQ,
            c_OP_J:    w_opLegal = 1'b1;
            c_OP_ADDI: w_opLegal = ADDI_EN;
            default:   w_opLegal = 1'b0;
        endcase
    end

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH: begin
                if (bus.memReady) begin
                    w_nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.opCode)
                    c_OP_LW:    w_nextState = S_MEM_ADDR_LW;
                    c_OP_SW:    w_nextState = S_MEM_ADDR_SW;
                    c_OP_RTYPE: w_nextState = S_EXECUTE;
                    c_OP_BEQ:   w_nextState = S_BRANCH;
                    c_OP_J:     w_nextState = S_JUMP;
                    default:    w_nextState = S_FETCH;
                endcase
                if (ADDI_EN && (bus.opCode == c_OP_ADDI)) begin
                    w_nextState = S_ADDI_EXEC;
                end
                if (!w_opLegal && HALT_ON_ILLEGAL) begin
                    w_nextState = S_HALT;
                end
            end
            S_MEM_ADDR_LW: w_nextState = S_MEM_READ;
            S_MEM_ADDR_SW: w_nextState = S_MEM_WRITE;
            S_MEM_READ: begin
                if (bus.memReady) begin
                    w_nextState = S_MEM_WB;
                end
            end
            S_MEM_WB:      w_nextState = S_FETCH;
            S_MEM_WRITE: begin
                if (bus.memReady) begin
                    w_nextState = S_FETCH;
                end
            end
            S_EXECUTE:     w_nextState = S_R_WB;
            S_R_WB:        w_nextState = S_FETCH;
            S_BRANCH:      w_nextState = S_FETCH;
            S_JUMP:        w_nextState = S_FETCH;
            S_ADDI_EXEC:   w_nextState = S_ADDI_WB;
            S_ADDI_WB:     w_nextState = S_FETCH;
            S_HALT:        w_nextState = S_HALT;
            default:       w_nextState = S_FETCH;
        endcase
    end

    //------------------------------------------------------------------------
    // Output decode
    //------------------------------------------------------------------------
    // While reset is held the outputs already show FETCH values, even before
    // the first edge has loaded the state register.
    assign w_outState = reset ? S_FETCH : r_state;

    always_comb begin
        w_pcWrite     = 1'b0;
        w_pcWriteCond = 1'b0;
        w_iorD        = 1'b0;
        w_memRead     = 1'b0;
        w_memWrite    = 1'b0;
        w_irWrite     = 1'b0;
        w_memToReg    = 1'b0;
        w_regDest     = 1'b0;
        w_regWrite    = 1'b0;
        w_aluSrcA     = 1'b0;
        w_aluSrcB     = 2'b00;
        w_aluOp       = 2'b00;
        w_pcSource    = 2'b00;
        w_instrDone   = 1'b0;
        w_illegalOp   = 1'b0;
        case (w_outState)
            S_FETCH: begin
                w_memRead = 1'b1;
                w_aluSrcB = 2'b01;
                // PC+4 and the IR load commit only once the fetch completes.
                w_pcWrite = bus.memReady;
                w_irWrite = bus.memReady;
            end
            S_DECODE: begin
                w_aluSrcB   = 2'b11;
                w_illegalOp = !w_opLegal;
                w_instrDone = !w_opLegal && !HALT_ON_ILLEGAL;
            end
            S_MEM_ADDR_LW,
            S_MEM_ADDR_SW,
            S_ADDI_EXEC: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b10;
            end
            S_MEM_READ: begin
                w_memRead = 1'b1;
                w_iorD    = 1'b1;
            end
            S_MEM_WB: begin
                w_memToReg  = 1'b1;
                w_regWrite  = 1'b1;
                w_instrDone = 1'b1;
            end
            S_MEM_WRITE: begin
                w_memWrite  = 1'b1;
                w_iorD      = 1'b1;
                w_instrDone = bus.memReady;
            end
            S_EXECUTE: begin
                w_aluSrcA = 1'b1;
                w_aluOp   = 2'b10;
            end
            S_R_WB: begin
                w_regDest   = 1'b1;
                w_regWrite  = 1'b1;
                w_instrDone = 1'b1;
            end
            S_BRANCH: begin
                w_aluSrcA     = 1'b1;
                w_aluOp       = 2'b01;
                w_pcWriteCond = 1'b1;
                w_pcSource    = 2'b01;
                w_instrDone   = 1'b1;
            end
            S_JUMP: begin
                w_pcWrite   = 1'b1;
                w_pcSource  = 2'b10;
                w_instrDone = 1'b1;
            end
            S_ADDI_WB: begin
                w_regWrite  = 1'b1;
                w_instrDone = 1'b1;
            end
            S_HALT: begin
                w_illegalOp = 1'b1;
            end
            default: begin
                w_illegalOp = 1'b0;
            end
        endcase
    end

    assign bus.pcWrite     = w_pcWrite;
    assign bus.pcWriteCond = w_pcWriteCond;
    assign bus.iorD        = w_iorD;
    assign bus.memRead     = w_memRead;
    assign bus.memWrite    = w_memWrite;
    assign bus.irWrite     = w_irWrite;
    assign bus.memToReg    = w_memToReg;
    assign bus.regDest     = w_regDest;
    assign bus.regWrite    = w_regWrite;
    assign bus.aluSrcA     = w_aluSrcA;
    assign bus.aluSrcB     = w_aluSrcB;
    assign bus.aluOp       = w_aluOp;
    assign bus.pcSource    = w_pcSource;
    assign bus.instrDone   = w_instrDone;
    assign bus.illegalOp   = w_illegalOp;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_multi_cycle_ctrl
// Description : Directed bench for multi_cycle_ctrl. Three instances share
//               clk, reset, opCode and memReady:
//                 dut 0 : ADDI_EN=1, HALT_ON_ILLEGAL=0
//                 dut 1 : ADDI_EN=0, HALT_ON_ILLEGAL=0
//                 dut 2 : ADDI_EN=1, HALT_ON_ILLEGAL=1
//               Each scenario starts with a reset and checks one instance's
//               full control word every cycle against hand-built constants.
// Revision    : 1.0 - initial release
//============================================================================
module tb_multi_cycle_ctrl;

    // Control word bit order:
    // pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg regDest
    // regWrite aluSrcA | aluSrcB[1:0] | aluOp[1:0] | pcSource[1:0] |
    // instrDone | illegalOp
    localparam logic [17:0] c_FETCH_RDY  = 18'b1001010000_01_00_00_0_0;
    localparam logic [17:0] c_FETCH_WAIT = 18'b0001000000_01_00_00_0_0;
    localparam logic [17:0] c_DECODE     = 18'b0000000000_11_00_00_0_0;
    localparam logic [17:0] c_DEC_SKIP   = 18'b0000000000_11_00_00_1_1;
    localparam logic [17:0] c_DEC_HALT   = 18'b0000000000_11_00_00_0_1;
    localparam logic [17:0] c_MEM_ADDR   = 18'b0000000001_10_00_00_0_0;
    localparam logic [17:0] c_MEM_READ   = 18'b0011000000_00_00_00_0_0;
    localparam logic [17:0] c_MEM_WB     = 18'b0000001010_00_00_00_1_0;
    localparam logic [17:0] c_MEMW_WAIT  = 18'b0010100000_00_00_00_0_0;
    localparam logic [17:0] c_MEMW_DONE  = 18'b0010100000_00_00_00_1_0;
    localparam logic [17:0] c_EXECUTE    = 18'b0000000001_00_10_00_0_0;
    localparam logic [17:0] c_R_WB       = 18'b0000000110_00_00_00_1_0;
    localparam logic [17:0] c_BRANCH     = 18'b0100000001_00_01_01_1_0;
    localparam logic [17:0] c_JUMP       = 18'b1000000000_00_00_10_1_0;
    localparam logic [17:0] c_ADDI_WB    = 18'b0000000010_00_00_00_1_0;
    localparam logic [17:0] c_HALT       = 18'b0000000000_00_00_00_0_1;

    localparam logic [5:0] c_RT   = 6'b000000;
    localparam logic [5:0] c_LW   = 6'b100011;
    localparam logic [5:0] c_SW   = 6'b101011;
    localparam logic [5:0] c_BEQ  = 6'b000100;
    localparam logic [5:0] c_J    = 6'b000010;
    localparam logic [5:0] c_ADDI = 6'b001000;
    localparam logic [5:0] c_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opCode;
    logic       memReady;

    int nVec = 0;
    int nMis = 0;

    logic [17:0] ctlWord [3];

    multi_cycle_ctrl_if bus0 ();
    multi_cycle_ctrl_if bus1 ();
    multi_cycle_ctrl_if bus2 ();

    assign bus0.opCode = opCode;  assign bus0.memReady = memReady;
    assign bus1.opCode = opCode;  assign bus1.memReady = memReady;
    assign bus2.opCode = opCode;  assign bus2.memReady = memReady;

    assign ctlWord[0] = {bus0.pcWrite, bus0.pcWriteCond, bus0.iorD, bus0.memRead,
                         bus0.memWrite, bus0.irWrite, bus0.memToReg, bus0.regDest,
                         bus0.regWrite, bus0.aluSrcA, bus0.aluSrcB, bus0.aluOp,
                         bus0.pcSource, bus0.instrDone, bus0.illegalOp};
    assign ctlWord[1] = {bus1.pcWrite, bus1.pcWriteCond, bus1.iorD, bus1.memRead,
                         bus1.memWrite, bus1.irWrite, bus1.memToReg, bus1.regDest,
                         bus1.regWrite, bus1.aluSrcA, bus1.aluSrcB, bus1.aluOp,
                         bus1.pcSource, bus1.instrDone, bus1.illegalOp};
    assign ctlWord[2] = {bus2.pcWrite, bus2.pcWriteCond, bus2.iorD, bus2.memRead,
                         bus2.memWrite, bus2.irWrite, bus2.memToReg, bus2.regDest,
                         bus2.regWrite, bus2.aluSrcA, bus2.aluSrcB, bus2.aluOp,
                         bus2.pcSource, bus2.instrDone, bus2.illegalOp};

    multi_cycle_ctrl #(.ADDI_EN(1'b1), .HALT_ON_ILLEGAL(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.master));
    multi_cycle_ctrl #(.ADDI_EN(1'b0), .HALT_ON_ILLEGAL(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.master));
    multi_cycle_ctrl #(.ADDI_EN(1'b1), .HALT_ON_ILLEGAL(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.master));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMis++;
            $display("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check just after.
    task automatic cyc(input int sel, input string tag, input logic [5:0] op,
                       input logic rdy, input logic [17:0] exp);
        @(negedge clk);
        reset    = 1'b0;
        opCode   = op;
        memReady = rdy;
        #1;
        chk(tag, ctlWord[sel], exp);
    endtask

    // Reset is held across one rising edge; FETCH values are expected while it is high.
    task automatic doReset(input int sel, input string tag);
        @(negedge clk);
        reset    = 1'b1;
        memReady = 1'b0;
        opCode   = c_BAD;
        #1;
        chk(tag, ctlWord[sel], c_FETCH_WAIT);
    endtask

    initial begin
        reset    = 1'b1;
        opCode   = c_RT;
        memReady = 1'b0;

        // R-type on dut 0, then the next fetch in cycle 5 (which begins lw)
        doReset(0, "rst0");
        cyc(0, "rt_fetch", c_RT,  1'b1, c_FETCH_RDY);
        cyc(0, "rt_dec",   c_RT,  1'b0, c_DECODE);
        cyc(0, "rt_exec",  c_SW,  1'b0, c_EXECUTE);
        cyc(0, "rt_wb",    c_J,   1'b1, c_R_WB);
        // lw with two wait cycles in MEM_READ: 7 cycles total
        cyc(0, "lw_fetch", c_LW,  1'b1, c_FETCH_RDY);
        cyc(0, "lw_dec",   c_LW,  1'b1, c_DECODE);
        cyc(0, "lw_addr",  c_SW,  1'b0, c_MEM_ADDR);
        cyc(0, "lw_rd0",   c_SW,  1'b0, c_MEM_READ);
        cyc(0, "lw_rd1",   c_BAD, 1'b0, c_MEM_READ);
        cyc(0, "lw_rd2",   c_LW,  1'b1, c_MEM_READ);
        cyc(0, "lw_wb",    c_SW,  1'b0, c_MEM_WB);
        // one stalled fetch, then sw / beq / j back-to-back
        cyc(0, "sw_stall", c_SW,  1'b0, c_FETCH_WAIT);
        cyc(0, "sw_fetch", c_SW,  1'b1, c_FETCH_RDY);
        cyc(0, "sw_dec",   c_SW,  1'b0, c_DECODE);
        cyc(0, "sw_addr",  c_LW,  1'b0, c_MEM_ADDR);
        cyc(0, "sw_wr",    c_LW,  1'b1, c_MEMW_DONE);
        cyc(0, "bq_fetch", c_BEQ, 1'b1, c_FETCH_RDY);
        cyc(0, "bq_dec",   c_BEQ, 1'b1, c_DECODE);
        cyc(0, "bq_br",    c_J,   1'b0, c_BRANCH);
        cyc(0, "j_fetch",  c_J,   1'b1, c_FETCH_RDY);
        cyc(0, "j_dec",    c_J,   1'b1, c_DECODE);
        cyc(0, "j_jump",   c_RT,  1'b0, c_JUMP);
        // addi legal on dut 0
        cyc(0, "ad_fetch", c_ADDI, 1'b1, c_FETCH_RDY);
        cyc(0, "ad_dec",   c_ADDI, 1'b1, c_DECODE);
        cyc(0, "ad_exec",  c_RT,   1'b0, c_MEM_ADDR);
        cyc(0, "ad_wb",    c_RT,   1'b0, c_ADDI_WB);
        // illegal opcode skipped on dut 0
        cyc(0, "il_fetch", c_BAD, 1'b1, c_FETCH_RDY);
        cyc(0, "il_dec",   c_BAD, 1'b1, c_DEC_SKIP);
        cyc(0, "il_next",  c_RT,  1'b1, c_FETCH_RDY);

        // addi treated as illegal (skip) on dut 1
        doReset(1, "rst1");
        cyc(1, "na_fetch", c_ADDI, 1'b1, c_FETCH_RDY);
        cyc(1, "na_dec",   c_ADDI, 1'b1, c_DEC_SKIP);
        cyc(1, "na_next",  c_ADDI, 1'b0, c_FETCH_WAIT);

        // illegal opcode halts dut 2 until reset
        doReset(2, "rst2");
        cyc(2, "h_fetch", c_BAD, 1'b1, c_FETCH_RDY);
        cyc(2, "h_dec",   c_BAD, 1'b1, c_DEC_HALT);
        for (int i = 0; i < 20; i++) begin
            cyc(2, "h_park", 6'(i), 1'(i % 2), c_HALT);
        end
        doReset(2, "h_rst");
        cyc(2, "h_after", c_RT, 1'b1, c_FETCH_RDY);

        // reset in the middle of a waiting store on dut 0
        doReset(0, "rst3");
        cyc(0, "mr_fetch", c_SW, 1'b1, c_FETCH_RDY);
        cyc(0, "mr_dec",   c_SW, 1'b1, c_DECODE);
        cyc(0, "mr_addr",  c_SW, 1'b1, c_MEM_ADDR);
        cyc(0, "mr_wait",  c_SW, 1'b0, c_MEMW_WAIT);
        doReset(0, "mr_rst");
        cyc(0, "mr_after", c_SW, 1'b0, c_FETCH_WAIT);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
